// File: rtl/apb_pkg.sv
// Shared types and constants for the two-requester APB master arbiter.
package apb_pkg;

  // Transfer sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_t;

  // Byte-strobe width of the APB write path.
  localparam int STB_WIDTH = 4;

  // Base address of the UART window on the shared interconnect.
  localparam logic [31:0] APB_UART_ADDR = 32'h0000_0400;

  // Turn a requester index into a one-hot requester vector.
  function automatic logic [1:0] grant_onehot(input logic idx);
    logic [1:0] vec;
    vec = idx ? 2'b10 : 2'b01;
    return vec;
  endfunction

endpackage

// File: rtl/apb_rr_pick.sv
// Combinational two-way round-robin picker: a lone requester wins outright,
// a tie goes to the requester that was not granted last time.
module apb_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant,
  output logic       valid
);

  // Decode the request pair into a winner index and a valid flag.
  always_comb begin
    grant = 1'b0;
    valid = 1'b0;
    case (req)
      2'b01: begin
        grant = 1'b0;
        valid = 1'b1;
      end
      2'b10: begin
        grant = 1'b1;
        valid = 1'b1;
      end
      2'b11: begin
        grant = ~last_grant;
        valid = 1'b1;
      end
      default: begin
        grant = 1'b0;
        valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master: round-robin arbitration, SETUP/ACCESS sequencing,
// per-requester response registers and a hung-slave timeout.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                            pclk,
  input  logic                            presetn,
  input  logic [1:0]                      rq_req,
  input  logic [1:0][ADDR_WIDTH-1:0]      rq_addr,
  input  logic [1:0][DATA_WIDTH-1:0]      rq_wdata,
  input  logic [1:0]                      rq_write,
  input  logic [1:0][STB_WIDTH-1:0]       rq_stb,
  output logic [1:0]                      rq_ack,
  output logic [1:0][DATA_WIDTH-1:0]      rq_rdata,
  output logic [1:0]                      rq_err,
  output logic                            psel,
  output logic                            penable,
  output logic                            pwrite,
  output logic [ADDR_WIDTH-1:0]           paddr,
  output logic [DATA_WIDTH-1:0]           pdata,
  output logic [STB_WIDTH-1:0]            pstb,
  input  logic [DATA_WIDTH-1:0]           prdata,
  input  logic                            pready,
  input  logic                            perr
);

  // Wait counter is at least one bit wide so a disabled timeout still elaborates.
  localparam int              CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam bit              TIMEOUT_EN = (TIMEOUT != 0);

  apb_state_t       state_r;
  apb_state_t       state_nxt_s;
  logic             grant_r;
  logic             last_grant_r;
  logic [CNT_W-1:0] wait_cnt_r;
  logic             pick_grant_s;
  logic             pick_valid_s;
  logic             latch_s;
  logic             complete_s;
  logic             timeout_s;

  apb_rr_pick u_pick (
    .req        (rq_req),
    .last_grant (last_grant_r),
    .grant      (pick_grant_s),
    .valid      (pick_valid_s)
  );

  // Next-state decode plus one-cycle event strobes for the datapath.
  always_comb begin
    state_nxt_s = state_r;
    latch_s     = 1'b0;
    complete_s  = 1'b0;
    timeout_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nxt_s = ST_SETUP;
          latch_s     = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_nxt_s = ST_ACCESS;
      end
      ST_ACCESS: begin
        // A slave answer on the limit cycle still counts as a normal completion.
        if (pready) begin
          complete_s  = 1'b1;
          state_nxt_s = ST_RESP;
        end else if (TIMEOUT_EN && (wait_cnt_r == CNT_LIMIT)) begin
          timeout_s   = 1'b1;
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_ACCESS;
        end
      end
      ST_RESP: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // APB phase controls registered from the next state so they align with it.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      psel    <= 1'b0;
      penable <= 1'b0;
    end else begin
      psel    <= (state_nxt_s == ST_SETUP) || (state_nxt_s == ST_ACCESS);
      penable <= (state_nxt_s == ST_ACCESS);
    end
  end

  // Capture the winner's transfer; bus fields hold their value between transfers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      paddr        <= {ADDR_WIDTH{1'b0}};
      pdata        <= {DATA_WIDTH{1'b0}};
      pwrite       <= 1'b0;
      pstb         <= {STB_WIDTH{1'b0}};
      grant_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (latch_s) begin
      paddr        <= rq_addr[pick_grant_s];
      pdata        <= rq_wdata[pick_grant_s];
      pwrite       <= rq_write[pick_grant_s];
      pstb         <= rq_stb[pick_grant_s];
      grant_r      <= pick_grant_s;
      last_grant_r <= pick_grant_s;
    end
  end

  // ACCESS-phase wait counter: cleared on entry, saturating while waiting.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == ST_SETUP) begin
      wait_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == ST_ACCESS) && (wait_cnt_r != CNT_MAX)) begin
      wait_cnt_r <= wait_cnt_r + CNT_ONE;
    end
  end

  // Per-requester response registers and the one-cycle completion pulse.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      rq_ack   <= 2'b00;
      rq_rdata <= '{default: {DATA_WIDTH{1'b0}}};
      rq_err   <= 2'b00;
    end else begin
      rq_ack <= (state_nxt_s == ST_RESP) ? grant_onehot(grant_r) : 2'b00;
      if (complete_s) begin
        rq_rdata[grant_r] <= prdata;
        rq_err[grant_r]   <= perr;
      end else if (timeout_s) begin
        rq_rdata[grant_r] <= {DATA_WIDTH{1'b0}};
        rq_err[grant_r]   <= 1'b1;
      end
    end
  end

endmodule
